apb_stream_master: RTL and testbench

//   Request/response stream to APB master bridge; sits directly upstream of apb_spi_master and drives its APB slave port.

---
 rtl/apb_stream_master_if.sv | 35 +++
 rtl/apb_stream_master.sv | 114 +++++++++++
 tb/tb_apb_stream_master.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/apb_stream_master_if.sv
// Bus bundle for apb_stream_master: request/response stream plus APB master signals.
// Signal directions in the names are from the bridge's point of view.
interface apb_stream_master_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 32
);
  logic              req_vld_i;
  logic              req_rdy_o;
  logic              req_write_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [DATA_W-1:0] req_wdata_i;
  logic              rsp_vld_o;
  logic              rsp_rdy_i;
  logic [DATA_W-1:0] rsp_rdata_o;
  logic              rsp_err_o;
  logic              psel_o;
  logic              penable_o;
  logic [ADDR_W-1:0] paddr_o;
  logic              pwrite_o;
  logic [DATA_W-1:0] pwdata_o;
  logic [DATA_W-1:0] prdata_i;
  logic              pready_i;

  modport master (
    input  req_vld_i, req_write_i, req_addr_i, req_wdata_i, rsp_rdy_i, prdata_i, pready_i,
    output req_rdy_o, rsp_vld_o, rsp_rdata_o, rsp_err_o,
           psel_o, penable_o, paddr_o, pwrite_o, pwdata_o
  );

  modport slave (
    output req_vld_i, req_write_i, req_addr_i, req_wdata_i, rsp_rdy_i, prdata_i, pready_i,
    input  req_rdy_o, rsp_vld_o, rsp_rdata_o, rsp_err_o,
           psel_o, penable_o, paddr_o, pwrite_o, pwdata_o
  );
endinterface

// File: rtl/apb_stream_master.sv
// Request/response stream to APB master bridge: one SETUP/ACCESS transfer per request,
// single transfer in flight, watchdog aborts ACCESS phases the slave never completes.
module apb_stream_master #(
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  pclk_i,
  input  logic                  rst_n_i,
  apb_stream_master_if.master   bus
);

  localparam int unsigned    WD_W    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_paddr;
  logic              r_pwrite;
  logic [DATA_W-1:0] r_pwdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic [WD_W-1:0]   r_wdog;
  logic              w_accept;
  logic              w_expire;
  logic              w_psel;
  logic              w_penable;
  logic              w_rsp_vld;
  logic              w_req_rdy;

  assign w_accept = (r_state == S_IDLE) && bus.req_vld_i;
  // Last allowed wait cycle with pready still low; pready in that cycle wins.
  assign w_expire = (TIMEOUT != 0) && (r_wdog == WD_LAST) && !bus.pready_i;

  always_ff @(posedge pclk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.req_vld_i)              w_next = S_SETUP;
      S_SETUP:                                  w_next = S_ACCESS;
      S_ACCESS: if (bus.pready_i || w_expire)   w_next = S_RESP;
      S_RESP:   if (bus.rsp_rdy_i)              w_next = S_IDLE;
      default:                                  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_req_rdy = 1'b0;
    w_psel    = 1'b0;
    w_penable = 1'b0;
    w_rsp_vld = 1'b0;
    case (r_state)
      S_IDLE:   w_req_rdy = 1'b1;
      S_SETUP:  w_psel    = 1'b1;
      S_ACCESS: begin
        w_psel    = 1'b1;
        w_penable = 1'b1;
      end
      S_RESP:   w_rsp_vld = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge pclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_paddr  <= '0;
      r_pwrite <= 1'b0;
      r_pwdata <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      r_wdog   <= '0;
    end else begin
      if (w_accept) begin
        r_paddr  <= bus.req_addr_i;
        r_pwrite <= bus.req_write_i;
        r_pwdata <= bus.req_wdata_i;
      end
      if (r_state == S_SETUP) r_wdog <= '0;
      if (r_state == S_ACCESS) begin
        if (bus.pready_i) begin
          r_rdata <= r_pwrite ? '0 : bus.prdata_i;
          r_err   <= 1'b0;
        end else if (w_expire) begin
          r_rdata <= '0;
          r_err   <= 1'b1;
        end else if (r_wdog != '1) begin
          r_wdog  <= r_wdog + WD_W'(1);
        end
      end
    end
  end

  assign bus.req_rdy_o   = w_req_rdy;
  assign bus.psel_o      = w_psel;
  assign bus.penable_o   = w_penable;
  assign bus.rsp_vld_o   = w_rsp_vld;
  assign bus.paddr_o     = r_paddr;
  assign bus.pwrite_o    = r_pwrite;
  assign bus.pwdata_o    = r_pwdata;
  assign bus.rsp_rdata_o = r_rdata;
  assign bus.rsp_err_o   = r_err;

endmodule

// File: tb/tb_apb_stream_master.sv
// Self-checking bench for apb_stream_master with a short watchdog (TIMEOUT = 4).
module tb_apb_stream_master;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  apb_stream_master_if #(.ADDR_W(4), .DATA_W(32)) bus ();

  apb_stream_master #(.ADDR_W(4), .DATA_W(32), .TIMEOUT(4)) dut (
    .pclk_i  (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    int unsigned waits;
    logic [31:0] prdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int unsigned exp_pen;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned pen;
  } exp_t;

  exp_t sbq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(input vec_t v, input bit hold);
    @(negedge clk);
    bus.req_vld_i   = 1'b1;
    bus.req_write_i = v.wr;
    bus.req_addr_i  = v.addr;
    bus.req_wdata_i = v.wdata;
    sbq.push_back('{v.exp_rdata, v.exp_err, v.exp_pen});
    @(posedge clk); #1;
    if (!hold) bus.req_vld_i = 1'b0;
  endtask

  // Entered one step after the accept edge; leaves in the RESP state.
  task automatic run_access(input vec_t v);
    int unsigned n;
    exp_t e;
    chk("setup_psel",    bus.psel_o, 1);
    chk("setup_penable", bus.penable_o, 0);
    chk("setup_req_rdy", bus.req_rdy_o, 0);
    chk("paddr",  bus.paddr_o, v.addr);
    chk("pwrite", bus.pwrite_o, v.wr);
    chk("pwdata", bus.pwdata_o, v.wdata);
    @(posedge clk); #1;
    n = 0;
    while (bus.penable_o === 1'b1 && n < 50) begin
      n++;
      chk("access_psel",  bus.psel_o, 1);
      chk("access_paddr", bus.paddr_o, v.addr);
      bus.pready_i = (n > v.waits);
      bus.prdata_i = v.prdata;
      @(posedge clk); #1;
    end
    bus.pready_i = 1'b0;
    bus.prdata_i = '0;
    if (sbq.size() == 0) begin
      total++; bad++;
      $display("FAIL sb_underflow: got empty queue expected one entry");
    end else begin
      e = sbq.pop_front();
      chk("rsp_vld",    bus.rsp_vld_o, 1);
      chk("rsp_psel",   bus.psel_o, 0);
      chk("rsp_rdata",  bus.rsp_rdata_o, e.rdata);
      chk("rsp_err",    bus.rsp_err_o, e.err);
      chk("pen_cycles", n, e.pen);
    end
  endtask

  task automatic finish_rsp();
    @(posedge clk); #1;
    chk("post_rsp_vld", bus.rsp_vld_o, 0);
    chk("post_req_rdy", bus.req_rdy_o, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    vec_t tv[7];
    vec_t v5a, v5b, v6, v7;
    logic [31:0] held_rdata;
    logic        held_err;

    // Hand-derived expectations with TIMEOUT = 4.
    tv[0] = '{1'b1, 4'h4, 32'hA5A50001, 0,  32'h0,        32'h0,        1'b0, 1};
    tv[1] = '{1'b0, 4'h8, 32'h0,        3,  32'h12345678, 32'h12345678, 1'b0, 4};
    tv[2] = '{1'b0, 4'hC, 32'h0,        20, 32'h55555555, 32'h0,        1'b1, 4};
    tv[3] = '{1'b0, 4'h2, 32'h0,        3,  32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 4};
    tv[4] = '{1'b1, 4'hF, 32'h0BADCAFE, 2,  32'hFFFFFFFF, 32'h0,        1'b0, 3};
    tv[5] = '{1'b0, 4'h0, 32'h0,        0,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1};
    tv[6] = '{1'b1, 4'h7, 32'h11112222, 9,  32'h33334444, 32'h0,        1'b1, 4};
    v5a   = '{1'b0, 4'h9, 32'h0,        1,  32'h0F0F0F0F, 32'h0F0F0F0F, 1'b0, 2};
    v5b   = '{1'b1, 4'hA, 32'h76543210, 0,  32'h99999999, 32'h0,        1'b0, 1};
    v6    = '{1'b0, 4'h3, 32'h0,        20, 32'h0,        32'h0,        1'b1, 4};
    v7    = '{1'b0, 4'h5, 32'h0,        1,  32'hABCD0123, 32'hABCD0123, 1'b0, 2};

    bus.req_vld_i   = 1'b0;
    bus.req_write_i = 1'b0;
    bus.req_addr_i  = '0;
    bus.req_wdata_i = '0;
    bus.rsp_rdy_i   = 1'b1;
    bus.prdata_i    = '0;
    bus.pready_i    = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_req_rdy", bus.req_rdy_o, 1);
    chk("rst_psel",    bus.psel_o, 0);
    chk("rst_penable", bus.penable_o, 0);
    chk("rst_rsp_vld", bus.rsp_vld_o, 0);
    chk("rst_rsp_err", bus.rsp_err_o, 0);
    chk("rst_rdata",   bus.rsp_rdata_o, 0);
    chk("rst_paddr",   bus.paddr_o, 0);
    chk("rst_pwrite",  bus.pwrite_o, 0);
    chk("rst_pwdata",  bus.pwdata_o, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      issue(tv[i], 1'b0);
      run_access(tv[i]);
      finish_rsp();
      chk("paddr_kept",  bus.paddr_o, tv[i].addr);
      chk("pwdata_kept", bus.pwdata_o, tv[i].wdata);
    end

    // Response back-pressure with the next request already waiting.
    bus.rsp_rdy_i = 1'b0;
    issue(v5a, 1'b1);
    run_access(v5a);
    held_rdata = bus.rsp_rdata_o;
    held_err   = bus.rsp_err_o;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_vld", bus.rsp_vld_o, 1);
      chk("bp_rdata",   bus.rsp_rdata_o, held_rdata);
      chk("bp_err",     bus.rsp_err_o, held_err);
      chk("bp_req_rdy", bus.req_rdy_o, 0);
      chk("bp_psel",    bus.psel_o, 0);
      @(posedge clk); #1;
    end
    bus.req_write_i = v5b.wr;
    bus.req_addr_i  = v5b.addr;
    bus.req_wdata_i = v5b.wdata;
    bus.rsp_rdy_i   = 1'b1;
    sbq.push_back('{v5b.exp_rdata, v5b.exp_err, v5b.exp_pen});
    @(posedge clk); #1;
    chk("hs_rsp_vld", bus.rsp_vld_o, 0);
    chk("hs_req_rdy", bus.req_rdy_o, 1);
    chk("hs_psel",    bus.psel_o, 0);
    @(posedge clk); #1;
    bus.req_vld_i = 1'b0;
    run_access(v5b);
    finish_rsp();

    // Asynchronous reset in the middle of an ACCESS phase.
    issue(v6, 1'b0);
    @(posedge clk); #1;
    chk("pre_rst_penable", bus.penable_o, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_psel",    bus.psel_o, 0);
    chk("arst_penable", bus.penable_o, 0);
    chk("arst_rsp_vld", bus.rsp_vld_o, 0);
    chk("arst_req_rdy", bus.req_rdy_o, 1);
    chk("arst_paddr",   bus.paddr_o, 0);
    void'(sbq.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    issue(v7, 1'b0);
    run_access(v7);
    finish_rsp();

    chk("sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
